// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side drain logic.
package fifo_pkg;

  localparam int unsigned DEF_DWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/rd_skid_buf.sv
// Small circular buffer that absorbs the FIFO read latency; head reads as 0 when empty.
module rd_skid_buf #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [DWIDTH-1:0]        i_wdata,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_occ,
  output logic [DWIDTH-1:0]        o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointer reset empties the buffer and head is gated.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_occ  = r_wr_ptr - r_rd_ptr;
  assign o_head = (o_occ != '0) ? r_mem[r_rd_ptr[AW-1:0]] : '0;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side master for the fifo: issues reads on credit and re-presents words as a valid/ready
// stream, counting delivered words.
module fifo_rd_drain #(
  parameter int unsigned DWIDTH    = fifo_pkg::DEF_DWIDTH,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              fifo_isempty,
  input  logic [DWIDTH-1:0] rdata,
  output logic              i_rreq,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count
);

  import fifo_pkg::*;

  localparam int unsigned AW = $clog2(BUF_DEPTH);

  drain_state_e     r_state;
  drain_state_e     w_state_nxt;
  logic             r_inflight;
  logic [CNT_W-1:0] r_count;

  logic [AW:0]        w_occ;
  logic [DWIDTH-1:0]  w_head;
  logic               w_empty;
  logic               w_pop;
  logic [AW+1:0]      w_used;
  logic [AW+1:0]      w_limit;

  rd_skid_buf #(
    .DWIDTH (DWIDTH),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (r_inflight),
    .i_wdata (rdata),
    .i_pop   (w_pop),
    .o_occ   (w_occ),
    .o_head  (w_head)
  );

  assign w_empty = (w_occ == '0);
  assign m_valid = !w_empty;
  assign m_data  = w_head;
  assign w_pop   = m_valid && m_ready;

  // Each outstanding read holds an entry; a pop this cycle frees the slot a new read lands in.
  assign w_used  = {1'b0, w_occ} + {{(AW+1){1'b0}}, r_inflight};
  assign w_limit = (AW+2)'(BUF_DEPTH) + {{(AW+1){1'b0}}, w_pop};
  assign i_rreq  = (r_state == RUN) && en && !fifo_isempty && (w_used < w_limit);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (en) w_state_nxt = RUN;
      RUN:     if (!en) w_state_nxt = (r_inflight || !w_empty) ? FLUSH : IDLE;
      FLUSH: begin
        if (en)                          w_state_nxt = RUN;
        else if (!r_inflight && w_empty) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= i_rreq;
      if (w_pop) r_count <= r_count + 1'b1;
    end
  end

  assign busy     = (r_state != IDLE);
  assign rd_count = r_count;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Scoreboard bench: a behavioural FIFO feeds the DUT; a negedge monitor checks the stream.
module tb_fifo_rd_drain;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          en;
  logic          fifo_isempty;
  logic [DW-1:0] rdata;
  logic          i_rreq;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          busy;
  logic [CW-1:0] rd_count;

  fifo_rd_drain #(
    .DWIDTH    (DW),
    .BUF_DEPTH (2),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .en           (en),
    .fifo_isempty (fifo_isempty),
    .rdata        (rdata),
    .i_rreq       (i_rreq),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .busy         (busy),
    .rd_count     (rd_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            rreq_cnt = 0;
  int            cyc = 0;
  int            first_hs = -1;
  int            last_hs = -1;
  logic [CW-1:0] mcount = '0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fq.push_back(d);
    exp_q.push_back(d);
    fifo_isempty = 1'b0;
  endtask

  // One clock: sample the read request at negedge, return data just after the rising edge.
  task automatic step();
    logic          took;
    logic [DW-1:0] nxt;
    nxt = '0;
    @(negedge clk);
    took = i_rreq;
    if (took) begin
      rreq_cnt++;
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo underflow: got read on empty fifo expected none");
        took = 1'b0;
      end else begin
        nxt = fq.pop_front();
      end
    end
    @(posedge clk);
    #1;
    if (took) rdata = nxt;
    fifo_isempty = (fq.size() == 0);
  endtask

  task automatic do_reset(input string name);
    resetn = 1'b0;
    #1;
    chk({name, " rreq"},     32'(i_rreq),   0);
    chk({name, " m_valid"},  32'(m_valid),  0);
    chk({name, " m_data"},   32'(m_data),   0);
    chk({name, " busy"},     32'(busy),     0);
    chk({name, " rd_count"}, 32'(rd_count), 0);
    exp_q  = fq;
    mcount = '0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic drain_to(input int n, input int budget, input string name);
    int i = 0;
    while (exp_q.size() > n && i < budget) begin
      step();
      i++;
    end
    chk(name, 32'(exp_q.size()), 32'(n));
  endtask

  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        stall_q = 1'b0;
      end else begin
        chk("mon rd_count", 32'(rd_count), 32'(mcount));
        if (stall_q) begin
          chk("mon hold valid", 32'(m_valid), 1);
          chk("mon hold data",  32'(m_data),  32'(stall_data));
        end
        if (!m_valid) chk("mon idle data", 32'(m_data), 0);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon extra word: got %0h expected none", m_data);
          end else begin
            e = exp_q.pop_front();
            chk("mon data", 32'(m_data), 32'(e));
          end
          mcount = mcount + 1'b1;
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
        end
        stall_q    = m_valid && !m_ready;
        stall_data = m_data;
      end
    end
  end

  initial begin
    resetn = 1'b0; en = 1'b0; m_ready = 1'b0; rdata = '0; fifo_isempty = 1'b1;
    @(posedge clk);
    #1;
    do_reset("init");

    // T1: reset with one read in flight; stream resumes at the fifo head
    en = 1'b1; m_ready = 1'b1;
    push(8'h11); push(8'h12); push(8'h13); push(8'h14);
    step(); step();
    do_reset("t1");
    drain_to(0, 30, "t1 drain");
    chk("t1 rd_count", 32'(rd_count), 3);

    // T2: back-to-back delivery
    do_reset("t2");
    first_hs = -1;
    push(8'hA1); push(8'hA2); push(8'hA3);
    drain_to(0, 30, "t2 drain");
    chk("t2 consecutive", 32'(last_hs - first_hs), 2);
    chk("t2 rd_count", 32'(rd_count), 3);

    // T3: backpressure limits reads to buffer credit
    m_ready = 1'b0; rreq_cnt = 0;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4); push(8'hB5);
    repeat (6) step();
    chk("t3 rreq pulses", 32'(rreq_cnt), 2);
    chk("t3 valid", 32'(m_valid), 1);
    chk("t3 head", 32'(m_data), 32'hB1);
    m_ready = 1'b1;
    drain_to(0, 40, "t3 drain");

    // T4: empty fifo, then a single word
    rreq_cnt = 0;
    repeat (5) step();
    chk("t4 rreq", 32'(rreq_cnt), 0);
    chk("t4 valid", 32'(m_valid), 0);
    push(8'h5C);
    step();
    chk("t4 valid +1", 32'(m_valid), 0);
    step();
    chk("t4 valid +2", 32'(m_valid), 1);
    chk("t4 data", 32'(m_data), 32'h5C);
    drain_to(0, 10, "t4 drain");

    // T5: en drops with one word in flight and one buffered
    m_ready = 1'b0;
    push(8'hC1); push(8'hC2);
    step(); step();
    en = 1'b0;
    push(8'hC3);
    rreq_cnt = 0;
    step();
    chk("t5 flush busy", 32'(busy), 1);
    m_ready = 1'b1;
    drain_to(1, 20, "t5 flush drain");
    step(); step();
    chk("t5 idle busy", 32'(busy), 0);
    chk("t5 no rreq", 32'(rreq_cnt), 0);
    chk("t5 valid", 32'(m_valid), 0);
    en = 1'b1;
    drain_to(0, 20, "t5 resume");

    // T6: delivered-word counter wraps
    do_reset("t6");
    for (int i = 0; i < 15; i++) push(8'(8'h30 + i));
    drain_to(0, 60, "t6 drain15");
    chk("t6 count 15", 32'(rd_count), 15);
    push(8'h4F);
    drain_to(0, 10, "t6 drain16");
    chk("t6 count wrap", 32'(rd_count), 0);
    push(8'h50);
    drain_to(0, 10, "t6 drain17");
    chk("t6 count 1", 32'(rd_count), 1);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
